// File: rtl/pip_alu_pipe_if.sv
// Handshake bundle between a producer/consumer and the three-stage ALU pipeline.
// The master side issues operations and accepts results; the slave side is the ALU.
interface pip_alu_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        instr;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] result;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        flags;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output in_valid, instr, data_a, data_b, out_ready,
    input  in_ready, result, out_valid, flags, retire_cnt
  );

  modport slave (
    input  in_valid, instr, data_a, data_b, out_ready,
    output in_ready, result, out_valid, flags, retire_cnt
  );
endinterface

// File: rtl/pip_alu_pipe.sv
// Three-stage ALU pipeline: S1 decode (input capture), S2 execute, S3 output.
// A single global stall (result presented but not taken) freezes every stage.
// flags = {illegal, ovf, carry, zero}; retire_cnt counts delivered results.
module pip_alu_pipe #(
  parameter int DATA_W = 8,
  parameter int SAT    = 0,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  pip_alu_pipe_if.slave bus
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;
  localparam logic [7:0] OP_SHL = 8'h06;
  localparam logic [7:0] OP_SHR = 8'h07;

  localparam bit                SAT_EN   = (SAT != 0);
  localparam logic [DATA_W-1:0] W_MOD    = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] ALL_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ALL_ONE  = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              stall_s;
  logic              accept_s;

  logic              s1_valid_r;
  logic [7:0]        s1_op_r;
  logic [DATA_W-1:0] s1_a_r;
  logic [DATA_W-1:0] s1_b_r;

  logic              s2_valid_r;
  logic [DATA_W-1:0] s2_result_r;
  logic [3:0]        s2_flags_r;

  logic              out_valid_r;
  logic [DATA_W-1:0] result_r;
  logic [3:0]        flags_r;
  logic [CNT_W-1:0]  retire_cnt_r;

  logic [DATA_W:0]   sum_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W-1:0] shamt_s;
  logic [DATA_W-1:0] exe_result_s;
  logic              illegal_s;
  logic              ovf_s;
  logic              carry_s;
  logic [3:0]        exe_flags_s;

  assign stall_s  = out_valid_r && !bus.out_ready;
  assign accept_s = bus.in_valid && !stall_s;

  // Execute-stage arithmetic/logic on the S1 operands, including saturation and flags.
  always_comb begin
    sum_s        = {1'b0, s1_a_r} + {1'b0, s1_b_r};
    diff_s       = {1'b0, s1_a_r} - {1'b0, s1_b_r};
    shamt_s      = s1_b_r % W_MOD;
    exe_result_s = ALL_ZERO;
    illegal_s    = 1'b0;
    ovf_s        = 1'b0;
    carry_s      = 1'b0;
    case (s1_op_r)
      OP_ADD: begin
        carry_s = sum_s[DATA_W];
        ovf_s   = (s1_a_r[DATA_W-1] == s1_b_r[DATA_W-1]) &&
                  (sum_s[DATA_W-1] != s1_a_r[DATA_W-1]);
        if (SAT_EN && sum_s[DATA_W]) begin
          exe_result_s = ALL_ONE;
        end else begin
          exe_result_s = sum_s[DATA_W-1:0];
        end
      end
      OP_SUB: begin
        carry_s = diff_s[DATA_W];
        ovf_s   = (s1_a_r[DATA_W-1] != s1_b_r[DATA_W-1]) &&
                  (diff_s[DATA_W-1] != s1_a_r[DATA_W-1]);
        if (SAT_EN && diff_s[DATA_W]) begin
          exe_result_s = ALL_ZERO;
        end else begin
          exe_result_s = diff_s[DATA_W-1:0];
        end
      end
      OP_AND:  exe_result_s = s1_a_r & s1_b_r;
      OP_OR:   exe_result_s = s1_a_r | s1_b_r;
      OP_XOR:  exe_result_s = s1_a_r ^ s1_b_r;
      OP_SHL:  exe_result_s = s1_a_r << shamt_s;
      OP_SHR:  exe_result_s = s1_a_r >> shamt_s;
      default: illegal_s    = 1'b1;
    endcase
    exe_flags_s = {illegal_s, ovf_s, carry_s, (exe_result_s == ALL_ZERO)};
  end

  // S1: capture accepted operations; NOPs and idle cycles become bubbles here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= OP_NOP;
      s1_a_r     <= ALL_ZERO;
      s1_b_r     <= ALL_ZERO;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s && (bus.instr != OP_NOP);
      s1_op_r    <= bus.instr;
      s1_a_r     <= bus.data_a;
      s1_b_r     <= bus.data_b;
    end
  end

  // S2: register the execute result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r  <= 1'b0;
      s2_result_r <= ALL_ZERO;
      s2_flags_r  <= 4'b0000;
    end else if (!stall_s) begin
      s2_valid_r  <= s1_valid_r;
      s2_result_r <= exe_result_s;
      s2_flags_r  <= exe_flags_s;
    end
  end

  // S3: output register; bubbles present zero result/flags so idle outputs are clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= ALL_ZERO;
      flags_r     <= 4'b0000;
    end else if (!stall_s) begin
      out_valid_r <= s2_valid_r;
      result_r    <= s2_valid_r ? s2_result_r : ALL_ZERO;
      flags_r     <= s2_valid_r ? s2_flags_r : 4'b0000;
    end
  end

  // Count results handed downstream; wraps naturally at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_r <= CNT_ZERO;
    end else if (out_valid_r && bus.out_ready) begin
      retire_cnt_r <= retire_cnt_r + CNT_ONE;
    end
  end

  assign bus.in_ready   = !stall_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.result     = result_r;
  assign bus.flags      = flags_r;
  assign bus.retire_cnt = retire_cnt_r;

endmodule

// File: doc/pip_alu_pipe.md
PIP_ALU_PIPE -- requirements
Module: pip_alu_pipe

Interface
REQ-001 Parameter DATA_W, 8, operand/result width (>=4).
REQ-002 Parameter SAT, 0, 1 = unsigned saturating ADD/SUB.
REQ-003 Parameter CNT_W, 16, retire-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 in_valid  in  1  instr/data_a/data_b valid.
REQ-007 in_ready  out  1  pipeline can accept this cycle.
REQ-008 instr  in  8  opcode.
REQ-009 data_a, data_b  in  DATA_W each  operands.
REQ-010 result  out  DATA_W  registered result.
REQ-011 out_valid  out  1  result/flags valid.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 flags  out  4  {illegal, ovf, carry, zero}, registered with result.
REQ-014 retire_cnt  out  CNT_W  count of delivered results.

Function
REQ-015 Three register stages: S1 decode (captures inputs), S2 execute, S3 output; each stage carries a valid bit.
REQ-016 Accept = in_valid && in_ready; stall = out_valid && !out_ready; in_ready = !stall.
REQ-017 Not stalled: all stages advance every cycle; in_valid=0 inserts a bubble. Stalled: every stage holds, inputs ignored.
REQ-018 Latency: item accepted at edge N drives result/out_valid after edge N+2; full throughput of one item per cycle, no stall.
REQ-019 Opcodes: 0x00 NOP, 0x01 ADD, 0x02 SUB (a-b), 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 SHL, 0x07 SHR logical; shift amount = data_b mod DATA_W.
REQ-020 NOP accepted but dropped at S1: no out_valid, no retire_cnt change.
REQ-021 Any other opcode illegal: result 0, flags 4'b1001, out_valid asserted.
REQ-022 Arithmetic modulo 2^DATA_W when SAT=0; SAT=1: ADD overflow clamps to all-ones, SUB borrow clamps to 0.
REQ-023 carry = ADD carry-out or SUB borrow (independent of SAT); 0 for other ops.
REQ-024 ovf = two's-complement signed overflow for ADD/SUB; 0 otherwise.
REQ-025 zero = (final result == 0), evaluated after saturation.
REQ-026 result/flags held stable while out_valid && !out_ready.
REQ-027 retire_cnt increments on out_valid && out_ready; wraps all-ones -> 0.
REQ-028 Stage registers with valid=0 hold don't-care data; out_valid=0 implies result/flags are 0.

Reset
REQ-029 reset asserted: immediately (no clock) out_valid=0, result=0, flags=0, retire_cnt=0, all stage valids=0.
REQ-030 reset mid-operation discards all in-flight items; none delivered after release.
REQ-031 in_ready=1 during and after reset; first accept possible at first edge after deassertion.

Verification (DATA_W=8, out_ready=1 unless stated)
REQ-032 ADD a=32 b=12 accepted at edge N -> result 44, flags 0000, out_valid after N+2; then SUB 32,12 -> 20.
REQ-033 SUB 12-32 SAT=0 -> 236, carry=1; SAT=1 -> 0, carry=1, zero=1. ADD 200+100 SAT=0 -> 44 carry=1; SAT=1 -> 255.
REQ-034 ADD 100+100 -> 200, ovf=1, carry=0; SHL a=0x81 b=9 -> 0x02; instr 0x09 -> result 0, flags 1001.
REQ-035 Stream 5 ops, out_ready low 3 cycles mid-stream -> in_ready low same cycles, no loss/duplication, order kept, retire_cnt=5.
REQ-036 NOP between two ADDs -> only 2 results, retire_cnt=2; reset asserted with 3 items in flight -> out_valid 0 at once, retire_cnt=0, no later output.
